// File: rtl/safety_apu_arbiter.sv
// Shares a single APU/FPU between NumReq cores: round-robin issue with request lock,
// and an in-order owner FIFO that routes every FPU result back to the core that issued it.
module safety_apu_arbiter #(
    parameter int NumReq         = 2,
    parameter int MaxOutstanding = 4,
    parameter int NumArgs        = 3,
    parameter int OpWidth        = 6,
    parameter int InFlagsWidth   = 15,
    parameter int OutFlagsWidth  = 5,
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
    localparam int CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumReq-1:0]                       apu_req_i,
    output logic [NumReq-1:0]                       apu_gnt_o,
    input  logic [NumReq-1:0][NumArgs-1:0][31:0]    apu_operands_i,
    input  logic [NumReq-1:0][OpWidth-1:0]          apu_op_i,
    input  logic [NumReq-1:0][InFlagsWidth-1:0]     apu_flags_i,
    output logic [NumReq-1:0]                       apu_rvalid_o,
    output logic [31:0]                             apu_result_o,
    output logic [OutFlagsWidth-1:0]                apu_rflags_o,
    output logic                                    fpu_req_o,
    input  logic                                    fpu_gnt_i,
    output logic [NumArgs-1:0][31:0]                fpu_operands_o,
    output logic [OpWidth-1:0]                      fpu_op_o,
    output logic [InFlagsWidth-1:0]                 fpu_flags_o,
    input  logic                                    fpu_rvalid_i,
    input  logic [31:0]                             fpu_result_i,
    input  logic [OutFlagsWidth-1:0]                fpu_rflags_i,
    output logic [CntW-1:0]                         outstanding_o,
    output logic                                    rsp_err_o
);

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [IdxW-1:0] fifo_d [MaxOutstanding];
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [IdxW-1:0] win_s, sel_s, head_s;
    logic            found_s, any_req_s, lock_drop_s, full_s, empty_s;
    logic            req_s, push_s, pop_s;
    int              cand_s;

    // Round-robin winner search starting at the pointer, wrapping modulo NumReq
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int i = 0; i < NumReq; i++) begin
            cand_s = int'(rr_q) + i;
            if (cand_s >= NumReq) begin
                cand_s = cand_s - NumReq;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && apu_req_i[cand_s]) begin
                win_s   = IdxW'(cand_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Issue-side selection; a locked requester keeps the FPU until it is granted
    always_comb begin
        if (lock_q) begin
            sel_s = lock_idx_q;
        end else begin
            sel_s = win_s;
        end
        any_req_s   = |apu_req_i;
        lock_drop_s = lock_q & ~apu_req_i[lock_idx_q];
        full_s      = (cnt_q == CntW'(MaxOutstanding));
        empty_s     = (cnt_q == CntW'(0));
        // Full is judged on the registered count so a same-cycle pop never feeds the request
        req_s       = rst_ni & any_req_s & ~full_s & ~lock_drop_s;
        push_s      = req_s & fpu_gnt_i;
        pop_s       = fpu_rvalid_i & ~empty_s;
        head_s      = fifo_q[rd_q];
    end

    // Request payload, grants and result routing
    always_comb begin
        fpu_req_o      = req_s;
        fpu_operands_o = '0;
        fpu_op_o       = '0;
        fpu_flags_o    = '0;
        apu_gnt_o      = '0;
        apu_rvalid_o   = '0;
        if (req_s) begin
            fpu_operands_o = apu_operands_i[sel_s];
            fpu_op_o       = apu_op_i[sel_s];
            fpu_flags_o    = apu_flags_i[sel_s];
        end else begin
            fpu_operands_o = '0;
        end
        for (int w = 0; w < NumReq; w++) begin
            apu_gnt_o[w]    = push_s & (sel_s == IdxW'(w));
            apu_rvalid_o[w] = pop_s & (head_s == IdxW'(w));
        end
        apu_result_o  = fpu_result_i;
        apu_rflags_o  = fpu_rflags_i;
        outstanding_o = cnt_q;
        rsp_err_o     = err_q;
    end

    // Next-state for pointer, lock, owner FIFO, occupancy and error flag
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        fifo_d     = fifo_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        err_d      = err_q | (fpu_rvalid_i & empty_s);

        if (push_s) begin
            lock_d = 1'b0;
            if (sel_s == IdxW'(NumReq - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = sel_s + IdxW'(1);
            end
            fifo_d[wr_q] = sel_s;
            if (wr_q == PtrW'(MaxOutstanding - 1)) begin
                wr_d = '0;
            end else begin
                wr_d = wr_q + PtrW'(1);
            end
        end else if (req_s) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_s;
        end else if (lock_drop_s) begin
            lock_d = 1'b0;
        end else begin
            lock_d = lock_q;
        end

        if (pop_s) begin
            if (rd_q == PtrW'(MaxOutstanding - 1)) begin
                rd_d = '0;
            end else begin
                rd_d = rd_q + PtrW'(1);
            end
        end else begin
            rd_d = rd_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

endmodule

// File: tb/tb_safety_apu_arbiter.sv
// Directed bench for safety_apu_arbiter: stimulus pushes expected grants/responses into
// queues, a negedge monitor pops and compares whenever the DUT presents a grant or rvalid.
module tb_safety_apu_arbiter;

    logic                    clk;
    logic                    rst_ni;
    logic [1:0]              apu_req_i;
    logic [1:0]              apu_gnt_o;
    logic [1:0][2:0][31:0]   apu_operands_i;
    logic [1:0][5:0]         apu_op_i;
    logic [1:0][14:0]        apu_flags_i;
    logic [1:0]              apu_rvalid_o;
    logic [31:0]             apu_result_o;
    logic [4:0]              apu_rflags_o;
    logic                    fpu_req_o;
    logic                    fpu_gnt_i;
    logic [2:0][31:0]        fpu_operands_o;
    logic [5:0]              fpu_op_o;
    logic [14:0]             fpu_flags_o;
    logic                    fpu_rvalid_i;
    logic [31:0]             fpu_result_i;
    logic [4:0]              fpu_rflags_i;
    logic [2:0]              outstanding_o;
    logic                    rsp_err_o;

    int tests = 0;
    int fails = 0;

    int          exp_gnt_q [$];
    int          exp_idx_q [$];
    logic [31:0] exp_res_q [$];
    int          mon_idx;
    logic [31:0] mon_res;

    safety_apu_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .apu_req_i      (apu_req_i),
        .apu_gnt_o      (apu_gnt_o),
        .apu_operands_i (apu_operands_i),
        .apu_op_i       (apu_op_i),
        .apu_flags_i    (apu_flags_i),
        .apu_rvalid_o   (apu_rvalid_o),
        .apu_result_o   (apu_result_o),
        .apu_rflags_o   (apu_rflags_o),
        .fpu_req_o      (fpu_req_o),
        .fpu_gnt_i      (fpu_gnt_i),
        .fpu_operands_o (fpu_operands_o),
        .fpu_op_o       (fpu_op_o),
        .fpu_flags_o    (fpu_flags_o),
        .fpu_rvalid_i   (fpu_rvalid_i),
        .fpu_result_i   (fpu_result_i),
        .fpu_rflags_i   (fpu_rflags_i),
        .outstanding_o  (outstanding_o),
        .rsp_err_o      (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic exp_rsp(input int idx, input logic [31:0] r);
        exp_idx_q.push_back(idx);
        exp_res_q.push_back(r);
    endtask

    task automatic drain(input logic [31:0] r);
        fpu_rvalid_i = 1'b1;
        fpu_result_i = r;
        fpu_rflags_i = r[4:0];
        settle();
        tick();
        fpu_rvalid_i = 1'b0;
        fpu_result_i = 32'h0;
        fpu_rflags_i = 5'h0;
    endtask

    // Scoreboard monitor: compares every presented grant and result against the queues
    always @(negedge clk) begin
        if (apu_gnt_o !== 2'b00) begin
            if (exp_gnt_q.size() == 0) begin
                chk("unexpected_gnt", 32'(apu_gnt_o), 32'h0);
            end else begin
                mon_idx = exp_gnt_q.pop_front();
                chk("gnt", 32'(apu_gnt_o), 32'h1 << mon_idx);
            end
        end
        if (apu_rvalid_o !== 2'b00) begin
            if (exp_idx_q.size() == 0) begin
                chk("unexpected_rvalid", 32'(apu_rvalid_o), 32'h0);
            end else begin
                mon_idx = exp_idx_q.pop_front();
                mon_res = exp_res_q.pop_front();
                chk("rvalid", 32'(apu_rvalid_o), 32'h1 << mon_idx);
                chk("result", apu_result_o, mon_res);
                chk("rflags", 32'(apu_rflags_o), 32'(mon_res[4:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni         = 1'b0;
        apu_req_i      = 2'b00;
        fpu_gnt_i      = 1'b0;
        fpu_rvalid_i   = 1'b0;
        fpu_result_i   = 32'h0;
        fpu_rflags_i   = 5'h0;
        apu_operands_i[0] = {32'h0A2, 32'h0A1, 32'h0A0};
        apu_operands_i[1] = {32'h1B2, 32'h1B1, 32'h1B0};
        apu_op_i[0]    = 6'h11;
        apu_op_i[1]    = 6'h22;
        apu_flags_i[0] = 15'h0101;
        apu_flags_i[1] = 15'h0202;

        // Reset state
        repeat (2) @(posedge clk);
        settle();
        chk("rst_gnt", 32'(apu_gnt_o), 32'h0);
        chk("rst_rvalid", 32'(apu_rvalid_o), 32'h0);
        chk("rst_fpu_req", 32'(fpu_req_o), 32'h0);
        chk("rst_outstanding", 32'(outstanding_o), 32'h0);
        chk("rst_err", 32'(rsp_err_o), 32'h0);
        tick();
        rst_ni = 1'b1;

        // Both cores request every cycle: grants alternate until the FIFO fills
        apu_req_i = 2'b11;
        fpu_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_gnt_q.push_back(k % 2);
            settle();
            chk("t1_op", 32'(fpu_op_o), (k % 2 == 1) ? 32'h22 : 32'h11);
            chk("t1_outstanding", 32'(outstanding_o), 32'(k));
            tick();
        end
        settle();
        chk("t1_full_req", 32'(fpu_req_o), 32'h0);
        chk("t1_full_cnt", 32'(outstanding_o), 32'h4);
        tick();
        apu_req_i = 2'b00;
        fpu_gnt_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_rsp(k % 2, 32'h100 + 32'(k));
            drain(32'h100 + 32'(k));
        end
        settle();
        chk("t1_drained", 32'(outstanding_o), 32'h0);
        tick();

        // Lock: core1 waits on a stalled FPU, core0 arrives but cannot pre-empt
        apu_req_i = 2'b10;
        settle();
        chk("t2_req", 32'(fpu_req_o), 32'h1);
        chk("t2_op_c1", 32'(fpu_op_o), 32'h22);
        tick();
        apu_req_i = 2'b11;
        settle();
        chk("t2_op_c2", 32'(fpu_op_o), 32'h22);
        chk("t2_flags_c2", 32'(fpu_flags_o), 32'h0202);
        chk("t2_operand_c2", fpu_operands_o[0], 32'h1B0);
        tick();
        settle();
        chk("t2_op_c3", 32'(fpu_op_o), 32'h22);
        tick();
        fpu_gnt_i = 1'b1;
        exp_gnt_q.push_back(1);
        settle();
        chk("t2_op_c4", 32'(fpu_op_o), 32'h22);
        tick();
        apu_req_i = 2'b01;
        exp_gnt_q.push_back(0);
        settle();
        tick();
        apu_req_i = 2'b00;
        fpu_gnt_i = 1'b0;
        exp_rsp(1, 32'h211);
        drain(32'h211);
        exp_rsp(0, 32'h222);
        drain(32'h222);

        // Issue order 0,1,1,0; results come back to the matching owner
        fpu_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apu_req_i = (k == 1 || k == 2) ? 2'b10 : 2'b01;
            exp_gnt_q.push_back((k == 1 || k == 2) ? 1 : 0);
            settle();
            tick();
        end
        apu_req_i = 2'b00;
        fpu_gnt_i = 1'b0;
        exp_rsp(0, 32'hA);
        drain(32'hA);
        exp_rsp(1, 32'hB);
        drain(32'hB);
        exp_rsp(1, 32'hC);
        drain(32'hC);
        exp_rsp(0, 32'hD);
        drain(32'hD);

        // Full FIFO with a same-cycle pop: no grant until the next cycle
        apu_req_i = 2'b11;
        fpu_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_gnt_q.push_back((k % 2 == 0) ? 1 : 0);
            settle();
            tick();
        end
        fpu_rvalid_i = 1'b1;
        fpu_result_i = 32'h55;
        fpu_rflags_i = 5'h15;
        exp_rsp(1, 32'h55);
        settle();
        chk("t4_full_req", 32'(fpu_req_o), 32'h0);
        chk("t4_cnt4", 32'(outstanding_o), 32'h4);
        tick();
        fpu_rvalid_i = 1'b0;
        exp_gnt_q.push_back(1);
        settle();
        chk("t4_req_after_pop", 32'(fpu_req_o), 32'h1);
        chk("t4_cnt3", 32'(outstanding_o), 32'h3);
        tick();
        apu_req_i = 2'b00;
        fpu_gnt_i = 1'b0;
        settle();
        chk("t4_cnt4_again", 32'(outstanding_o), 32'h4);
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_rsp(k % 2, 32'h400 + 32'(k));
            drain(32'h400 + 32'(k));
        end

        // Spurious result with nothing in flight
        settle();
        chk("t5_empty", 32'(outstanding_o), 32'h0);
        tick();
        fpu_rvalid_i = 1'b1;
        fpu_result_i = 32'h77;
        settle();
        chk("t5_no_rvalid", 32'(apu_rvalid_o), 32'h0);
        chk("t5_err_before", 32'(rsp_err_o), 32'h0);
        tick();
        fpu_rvalid_i = 1'b0;
        settle();
        chk("t5_err_set", 32'(rsp_err_o), 32'h1);
        repeat (3) tick();
        settle();
        chk("t5_err_sticky", 32'(rsp_err_o), 32'h1);
        tick();

        // Reset with two ops in flight
        apu_req_i = 2'b11;
        fpu_gnt_i = 1'b1;
        exp_gnt_q.push_back(0);
        settle();
        tick();
        exp_gnt_q.push_back(1);
        settle();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_gnt", 32'(apu_gnt_o), 32'h0);
        chk("t6_fpu_req", 32'(fpu_req_o), 32'h0);
        chk("t6_outstanding", 32'(outstanding_o), 32'h0);
        chk("t6_err", 32'(rsp_err_o), 32'h0);
        apu_req_i = 2'b00;
        fpu_gnt_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        fpu_rvalid_i = 1'b1;
        fpu_result_i = 32'h66;
        settle();
        chk("t6_stale_rvalid", 32'(apu_rvalid_o), 32'h0);
        tick();
        fpu_rvalid_i = 1'b0;
        settle();
        chk("t6_stale_err", 32'(rsp_err_o), 32'h1);
        tick();
        apu_req_i = 2'b11;
        fpu_gnt_i = 1'b1;
        exp_gnt_q.push_back(0);
        settle();
        tick();
        apu_req_i = 2'b00;
        fpu_gnt_i = 1'b0;
        exp_rsp(0, 32'h600);
        drain(32'h600);

        settle();
        chk("final_outstanding", 32'(outstanding_o), 32'h0);
        chk("gnt_queue_left", 32'(exp_gnt_q.size()), 32'h0);
        chk("rsp_queue_left", 32'(exp_idx_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
